// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped, one-word-per-line instruction cache
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  input  logic        flush,
  output logic        ins_valid,
  output logic [31:0] ins,
  input  logic        mem_enable,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ins_rdy,
  input  logic [31:0] mem_ins,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, MISS_DRAIN} state_t;

  state_t                r_state;
  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [31:0]           r_data [LINES];
  logic                  r_ins_valid;
  logic [31:0]           r_ins;
  logic                  r_mem_req;
  logic [31:0]           r_mem_addr;

  logic [INDEX_BITS-1:0] w_idx;
  logic [INDEX_BITS-1:0] w_fill_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [TAG_W-1:0]      w_fill_tag;
  logic                  w_hit;
  logic                  w_lookup;
  logic                  w_fill;

  assign w_idx      = if_pc[INDEX_BITS+1:2];
  assign w_tag      = if_pc[31:INDEX_BITS+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_lookup   = (r_state == IDLE) && if_req && !flush;
  // The outstanding miss address doubles as the fill address.
  assign w_fill_idx = r_mem_addr[INDEX_BITS+1:2];
  assign w_fill_tag = r_mem_addr[31:INDEX_BITS+2];
  assign w_fill     = rdy && mem_ins_rdy && ((r_state == MISS_WAIT) || (r_state == MISS_DRAIN));

  assign if_ready   = (r_state == IDLE) && !rst;
  assign ins_valid  = r_ins_valid;
  assign ins        = r_ins;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;

  // Tag/data arrays carry no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!rst && w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_ins;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_ins_valid <= 1'b0;
      r_ins       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
    end else if (rdy) begin
      r_ins_valid <= 1'b0;
      r_mem_req   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_lookup) begin
            if (w_hit) begin
              r_ins       <= r_data[w_idx];
              r_ins_valid <= 1'b1;
            end else begin
              r_mem_addr <= if_pc & 32'hFFFF_FFFC;
              r_state    <= MISS_REQ;
            end
          end
        end
        MISS_REQ: begin
          if (flush) begin
            r_state <= IDLE;
          end else if (mem_enable) begin
            r_mem_req <= 1'b1;
            r_state   <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (mem_ins_rdy) begin
            r_valid[w_fill_idx] <= 1'b1;
            if (!flush) begin
              r_ins       <= mem_ins;
              r_ins_valid <= 1'b1;
            end
            r_state <= IDLE;
          end else if (flush) begin
            r_state <= MISS_DRAIN;
          end
        end
        MISS_DRAIN: begin
          if (mem_ins_rdy) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_state             <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (rdy && w_lookup) begin
      if (w_hit) r_hit_count  <= r_hit_count + 32'd1;
      else       r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - self-checking bench for icache_direct
module tb_icache_direct;
`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_pc = '0;
  logic        if_ready;
  logic        flush = 1'b0;
  logic        ins_valid;
  logic [31:0] ins;
  logic        mem_enable = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ins_rdy = 1'b0;
  logic [31:0] mem_ins = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_direct #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_req(if_req), .if_pc(if_pc),
    .if_ready(if_ready), .flush(flush), .ins_valid(ins_valid), .ins(ins),
    .mem_enable(mem_enable), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ins_rdy(mem_ins_rdy), .mem_ins(mem_ins),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_req = 0;
  int n_ins = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0104) return 32'h00A0_0093;
    if (a == 32'h0000_0300) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction

  task automatic chk_stats(input string tag);
    chk({tag, "_hit_count"}, hit_count, STATS ? exp_hits : 0);
    chk({tag, "_miss_count"}, miss_count, STATS ? exp_misses : 0);
  endtask

  // Scoreboard consumer and protocol monitor.
  always @(negedge clk) begin
    if (!rst && rdy) begin
      if (ins_valid) begin
        n_ins++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ins_valid: got ins=%h, required no pulse", ins);
        end else begin
          chk("scoreboard_ins", ins, exp_q.pop_front());
        end
      end
      if (mem_req) begin
        n_req++;
        if (!mem_enable) begin
          n_chk++;
          n_fail++;
          $display("FAIL mem_req_without_enable: got mem_req=1, required 0");
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] pc, input bit miss, input int busy);
    int cyc;
    int req0;
    logic [31:0] a;
    a = pc & 32'hFFFF_FFFC;
    cyc = 0;
    while (!if_ready && cyc < 50) begin step(); cyc++; end
    chk("if_ready_before_req", 32'(if_ready), 32'd1);
    req0 = n_req;
    mem_enable = (busy == 0);
    exp_q.push_back(mem_word(a));
    if_req = 1'b1;
    if_pc = pc;
    step();
    if_req = 1'b0;
    if (!miss) begin
      exp_hits++;
      chk("hit_latency", 32'(ins_valid), 32'd1);
    end else begin
      exp_misses++;
      for (int i = 0; i < busy; i++) begin
        step();
        chk("busy_no_mem_req", 32'(mem_req), 32'd0);
      end
      mem_enable = 1'b1;
      cyc = 0;
      while (!mem_req && cyc < 50) begin step(); cyc++; end
      chk("mem_req_latency", cyc, 32'd1);
      chk("mem_addr", mem_addr, a);
      step();
      mem_ins_rdy = 1'b1;
      mem_ins = mem_word(a);
      step();
      mem_ins_rdy = 1'b0;
      mem_ins = '0;
      chk("fill_ins_valid", 32'(ins_valid), 32'd1);
      chk("fill_if_ready", 32'(if_ready), 32'd1);
    end
    step();
    chk("mem_req_pulses", n_req - req0, 32'(miss));
    chk_stats("fetch");
  endtask

  typedef struct {
    logic [31:0] pc;
    bit          miss;
    int          busy;
  } vec_t;

  vec_t vecs[13];
  int req0;
  int ins0;

  initial begin
    vecs[0]  = '{32'h0000_0104, 1'b1, 0};
    vecs[1]  = '{32'h0000_0104, 1'b0, 0};
    vecs[2]  = '{32'h0000_0106, 1'b0, 0};
    vecs[3]  = '{32'h0000_0204, 1'b1, 0};
    vecs[4]  = '{32'h0000_0104, 1'b1, 0};
    vecs[5]  = '{32'h0000_0208, 1'b1, 5};
    vecs[6]  = '{32'h0000_0104, 1'b0, 0};
    vecs[7]  = '{32'h0000_020A, 1'b0, 0};
    vecs[8]  = '{32'h0000_0000, 1'b1, 0};
    vecs[9]  = '{32'hFFFF_FFFC, 1'b1, 0};
    vecs[10] = '{32'h0000_00FC, 1'b1, 0};
    vecs[11] = '{32'hFFFF_FFFC, 1'b1, 0};
    vecs[12] = '{32'h0000_0000, 1'b0, 0};

    repeat (3) step();
    chk("reset_if_ready", 32'(if_ready), 32'd0);
    chk("reset_ins_valid", 32'(ins_valid), 32'd0);
    chk("reset_ins", ins, 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk_stats("reset");
    rst = 1'b0;
    step();
    chk("idle_if_ready", 32'(if_ready), 32'd1);

    for (int i = 0; i < 13; i++) do_fetch(vecs[i].pc, vecs[i].miss, vecs[i].busy);

    // Back-to-back hits on consecutive cycles.
    req0 = n_req;
    ins0 = n_ins;
    exp_q.push_back(mem_word(32'h104));
    exp_q.push_back(mem_word(32'h208));
    if_req = 1'b1;
    if_pc = 32'h104;
    step();
    chk("b2b_first_valid", 32'(ins_valid), 32'd1);
    if_pc = 32'h20A;
    step();
    if_req = 1'b0;
    chk("b2b_second_valid", 32'(ins_valid), 32'd1);
    step();
    exp_hits += 2;
    chk("b2b_pulses", n_ins - ins0, 32'd2);
    chk("b2b_no_mem_req", n_req - req0, 32'd0);
    chk_stats("b2b");

    // rdy=0 freezes an already-high ins_valid pulse.
    exp_q.push_back(mem_word(32'h104));
    if_req = 1'b1;
    if_pc = 32'h104;
    step();
    if_req = 1'b0;
    chk("rdy_pulse", 32'(ins_valid), 32'd1);
    @(negedge clk);
    #1 rdy = 1'b0;
    step();
    chk("rdy_hold_valid", 32'(ins_valid), 32'd1);
    chk("rdy_hold_ins", ins, 32'h00A0_0093);
    @(negedge clk);
    #1 rdy = 1'b1;
    step();
    chk("rdy_release", 32'(ins_valid), 32'd0);
    exp_hits++;
    chk_stats("rdy");

    // if_req together with flush in IDLE is ignored.
    req0 = n_req;
    ins0 = n_ins;
    if_req = 1'b1;
    flush = 1'b1;
    if_pc = 32'h104;
    step();
    if_req = 1'b0;
    flush = 1'b0;
    chk("idle_flush_no_valid", 32'(ins_valid), 32'd0);
    chk("idle_flush_ready", 32'(if_ready), 32'd1);
    chk_stats("idle_flush");

    // Flush during MISS_WAIT: fill arrives 3 cycles later, no pulse.
    if_req = 1'b1;
    if_pc = 32'h300;
    step();
    if_req = 1'b0;
    exp_misses++;
    step();
    chk("mw_mem_req", 32'(mem_req), 32'd1);
    chk("mw_mem_addr", mem_addr, 32'h300);
    flush = 1'b1;
    step();
    chk("mw_drain_not_ready", 32'(if_ready), 32'd0);
    step();
    chk("mw_drain_not_ready2", 32'(if_ready), 32'd0);
    step();
    flush = 1'b0;
    chk("mw_drain_not_ready3", 32'(if_ready), 32'd0);
    mem_ins_rdy = 1'b1;
    mem_ins = 32'hDEAD_BEEF;
    step();
    mem_ins_rdy = 1'b0;
    mem_ins = '0;
    chk("mw_fill_no_valid", 32'(ins_valid), 32'd0);
    chk("mw_fill_ready", 32'(if_ready), 32'd1);
    step();
    chk("mw_no_pulses", n_ins - ins0, 32'd0);
    chk("mw_one_req", n_req - req0, 32'd1);
    do_fetch(32'h300, 1'b0, 0);

    // Flush in MISS_REQ: back to IDLE, no request ever issued.
    req0 = n_req;
    mem_enable = 1'b0;
    if_req = 1'b1;
    if_pc = 32'h500;
    step();
    if_req = 1'b0;
    exp_misses++;
    step();
    chk("mr_not_ready", 32'(if_ready), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("mr_flush_idle", 32'(if_ready), 32'd1);
    mem_enable = 1'b1;
    step();
    step();
    chk("mr_no_mem_req", n_req - req0, 32'd0);
    chk_stats("mr");

    // Reset mid-miss; a late mem_ins_rdy is ignored and lines are invalid.
    if_req = 1'b1;
    if_pc = 32'h600;
    step();
    if_req = 1'b0;
    step();
    chk("rm_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    step();
    chk("rm_rst_not_ready", 32'(if_ready), 32'd0);
    chk("rm_mem_addr", mem_addr, 32'd0);
    exp_hits = 0;
    exp_misses = 0;
    chk_stats("rm");
    rst = 1'b0;
    mem_ins_rdy = 1'b1;
    mem_ins = 32'h1234_5678;
    step();
    mem_ins_rdy = 1'b0;
    mem_ins = '0;
    chk("rm_late_rdy_ignored", 32'(ins_valid), 32'd0);
    chk("rm_idle", 32'(if_ready), 32'd1);
    do_fetch(32'h104, 1'b1, 0);
    do_fetch(32'h104, 1'b0, 0);

    step();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache between the fetch unit and the memory controller's instruction port.
- Serves fetch lookups from the cache.
- On a miss, issues a single word request to the memory controller.
- Fills the line from the returned word and forwards it to fetch.
- Implements the requesting end of the controller's instruction interface (request pulse / enable / ready pulse).

Parameters:
INDEX_BITS, 6, log2 of line count (64 lines); tag = pc[31:INDEX_BITS+2], index = pc[INDEX_BITS+1:2].

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
rdy  input  1  global ready; when 0 all state holds
if_req  input  1  fetch requests instruction at if_pc (honoured only when if_ready=1)
if_pc  input  32  fetch address; bits [1:0] ignored
if_ready  output  1  cache can accept a request this cycle
flush  input  1  discard outstanding fetch (branch redirect)
ins_valid  output  1  one-cycle pulse: ins holds the requested word
ins  output  32  instruction word
mem_enable  input  1  memory controller can accept an instruction request
mem_req  output  1  one-cycle request pulse to memory controller
mem_addr  output  32  word-aligned miss address
mem_ins_rdy  input  1  one-cycle pulse: mem_ins valid
mem_ins  input  32  word returned by memory controller
hit_count  output  32  hit counter (see Optional Feature)
miss_count  output  32  miss counter (see Optional Feature)

Behaviour:
- Storage per line: valid bit, tag, 32-bit data. Reset clears every valid bit.
- Reset values: ins_valid=0, ins=0, mem_req=0, mem_addr=0, hit_count=0, miss_count=0; state IDLE.
- rdy=0: no state, array or output change; pulses already high stay high.
- if_ready = (state==IDLE) && !rst. Combinational.
- States: IDLE, MISS_REQ, MISS_WAIT, MISS_DRAIN. ins_valid and mem_req default to 0 every cycle unless set below.
- IDLE:
  - If_req with flush=0 and a hit: ins<=line data, ins_valid<=1. Hit latency is 1 cycle; back-to-back hits are allowed every cycle.
  - Miss: latch mem_addr<={if_pc[31:2],2'b00} and go to MISS_REQ.
  - if_req together with flush: request ignored, no state change.
- MISS_REQ:
  - flush=1: go to IDLE with no request issued.
  - Else if mem_enable=1: mem_req<=1 for exactly one cycle, go to MISS_WAIT.
  - Else wait.
- MISS_WAIT:
  - mem_ins_rdy=1: write line (valid=1, tag, data=mem_ins). If flush=0 in the same cycle: ins<=mem_ins, ins_valid<=1. Go to IDLE either way.
  - flush=1 without mem_ins_rdy: go to MISS_DRAIN.
- MISS_DRAIN:
  - Wait for mem_ins_rdy, fill the line, do not assert ins_valid, go to IDLE.
  - Further flushes have no effect.
- At most one memory request is ever outstanding. mem_req never asserts while mem_enable=0.
- A fill overwrites any valid line at the same index (no replacement policy).
- flush never invalidates lines.
- Reset mid-miss returns to IDLE with all lines invalid. A later mem_ins_rdy in IDLE is ignored.
- mem_ins_rdy outside MISS_WAIT/MISS_DRAIN is ignored.
- mem_addr holds its value until the next miss.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined: hit_count increments on each served IDLE hit. miss_count increments on each IDLE miss, counted at the transition to MISS_REQ, including misses later flushed. Both counters wrap modulo 2^32 and are cleared by rst.
- Undefined: hit_count and miss_count are tied to 0 and no counter registers exist.

Test Plan:
- Cold miss:
  - Stimulus: after reset, if_req pc=0x00000104; mem_enable=1.
  - Required: mem_req pulses once with mem_addr=0x104. On mem_ins_rdy with mem_ins=0x00A00093, ins_valid pulses next cycle with ins=0x00A00093 and if_ready returns to 1.
- Hit and back-to-back:
  - Stimulus: re-request 0x104, then 0x106 on consecutive cycles.
  - Required: two ins_valid pulses, both ins=0x00A00093, no mem_req. With ICACHE_STATS_EN: hit_count=2, miss_count=1.
- Conflict eviction:
  - Stimulus: fill 0x104, then request 0x204 (same index, INDEX_BITS=6), then 0x104 again.
  - Required: three misses and three mem_req pulses.
- Controller busy:
  - Stimulus: miss while mem_enable=0 for 5 cycles.
  - Required: mem_req stays 0, then pulses the cycle after mem_enable rises.
- Flush during MISS_WAIT:
  - Stimulus: flush while waiting; mem_ins_rdy arrives 3 cycles later with 0xDEADBEEF.
  - Required: no ins_valid, if_ready=0 until fill. A following request to the same pc hits with ins=0xDEADBEEF.
- Flush in MISS_REQ and reset mid-miss:
  - Required: no mem_req and immediate IDLE after the flush.
  - Required: after reset, the previously filled pc misses again.
